// File: rtl/scan_mux_n.sv
// Time-multiplexed display scanner: drives one digit at a time with a
// programmable dwell per digit, a blank interval at the start of each slot,
// a per-digit enable mask and a frame-coherent snapshot of the digit data.
module scan_mux_n #(
  parameter int DIGITS         = 8,
  parameter int DW             = 4,
  parameter int DIV            = 50000,
  parameter int BLANK          = 16,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIGITS*DW-1:0] din,
  input  logic [DIGITS-1:0]    en,
  input  logic                 hold,
  output logic [DW-1:0]        outm,
  output logic [DIGITS-1:0]    selmo,
  output logic                 frame_start
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_IDLE = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DIGITS*DW-1:0] shadow_din;
  logic [DIGITS-1:0]    shadow_en;
  logic                 init;

  logic slot_wrap;
  logic frame_wrap;
  logic snap;
  logic blanked;

  // One-hot select for the current slot, converted to the board polarity.
  function automatic logic [DIGITS-1:0] sel_decode(input logic             blank_now,
                                                   input logic [IW-1:0]     digit,
                                                   input logic [DIGITS-1:0] mask);
    logic [DIGITS-1:0] onehot;
    onehot = '0;
    if (!blank_now && mask[digit]) onehot[digit] = 1'b1;
    return (SEL_ACTIVE_LOW != 0) ? ~onehot : onehot;
  endfunction

  assign slot_wrap  = (cnt == CNT_LAST);
  assign frame_wrap = slot_wrap && (idx == IDX_LAST);
  // A snapshot is taken on the first live edge after reset and at each frame end.
  assign snap       = init || frame_wrap;

  // Blank phase covers the first BLANK cycles of every slot.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign blanked = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
      assign blanked = (cnt < BLANK_C);
    end
  endgenerate

  // Slot and digit position counters; frozen while hold is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (!hold) begin
      cnt <= slot_wrap ? '0 : cnt + 1'b1;
      if (slot_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Frame snapshot of digit data and enable mask, so mid-frame changes wait a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_din <= '0;
      shadow_en  <= '0;
      init       <= 1'b1;
    end else if (!hold) begin
      if (snap) begin
        shadow_din <= din;
        shadow_en  <= en;
      end
      init <= 1'b0;
    end
  end

  // Registered outputs: value always tracks the slot so it settles before select asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outm        <= '0;
      selmo       <= SEL_IDLE;
      frame_start <= 1'b0;
    end else if (hold) begin
      frame_start <= 1'b0;
    end else begin
      outm        <= shadow_din[idx*DW +: DW];
      selmo       <= sel_decode(blanked, idx, shadow_en);
      frame_start <= snap;
    end
  end

endmodule

// File: tb/tb_scan_mux_n.sv
// Bench for scan_mux_n: two instances (4-digit active-low with blanking, and
// 3-digit active-high without blanking) checked every cycle against a
// position-based model, plus hand-computed expectations at chosen edges.
module tb_scan_mux_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [15:0] din_a = 16'h4321;
  logic [3:0]  en_a  = 4'hF;
  logic        hold_a = 1'b0;
  logic [3:0]  outm_a;
  logic [3:0]  selmo_a;
  logic        fs_a;

  logic [11:0] din_b = 12'h321;
  logic [2:0]  en_b  = 3'b111;
  logic        hold_b = 1'b0;
  logic [3:0]  outm_b;
  logic [2:0]  selmo_b;
  logic        fs_b;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;

  scan_mux_n #(.DIGITS(4), .DW(4), .DIV(8), .BLANK(2), .SEL_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .en(en_a), .hold(hold_a),
    .outm(outm_a), .selmo(selmo_a), .frame_start(fs_a)
  );

  scan_mux_n #(.DIGITS(3), .DW(4), .DIV(2), .BLANK(0), .SEL_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .en(en_b), .hold(hold_b),
    .outm(outm_b), .selmo(selmo_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Edge counter since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Model A: position within a 32-cycle frame; digit = pos/8, slot cycle = pos%8.
  int          ma_pos;
  logic        ma_init;
  logic [15:0] ma_sd;
  logic [3:0]  ma_se;
  logic [3:0]  ea_out, ea_sel;
  logic        ea_fs;
  always @(posedge clk or negedge rst_n) begin : model_a
    int d, c;
    if (!rst_n) begin
      ma_pos = 0; ma_init = 1'b1; ma_sd = '0; ma_se = '0;
      ea_out = '0; ea_sel = 4'hF; ea_fs = 1'b0;
    end else if (hold_a) begin
      ea_fs = 1'b0;
    end else begin
      d = ma_pos / 8;
      c = ma_pos % 8;
      ea_out = ma_sd[d*4 +: 4];
      ea_sel = (c >= 2 && ma_se[d]) ? ~(4'b0001 << d) : 4'hF;
      ea_fs  = ma_init || (ma_pos == 31);
      if (ea_fs) begin
        ma_sd = din_a; ma_se = en_a; ma_init = 1'b0;
      end
      ma_pos = (ma_pos + 1) % 32;
    end
  end

  // Model B: 6-cycle frame, two cycles per digit, no blanking, active-high.
  int          mb_pos;
  logic        mb_init;
  logic [11:0] mb_sd;
  logic [2:0]  mb_se;
  logic [3:0]  eb_out;
  logic [2:0]  eb_sel;
  logic        eb_fs;
  always @(posedge clk or negedge rst_n) begin : model_b
    int d;
    if (!rst_n) begin
      mb_pos = 0; mb_init = 1'b1; mb_sd = '0; mb_se = '0;
      eb_out = '0; eb_sel = 3'b000; eb_fs = 1'b0;
    end else if (hold_b) begin
      eb_fs = 1'b0;
    end else begin
      d = mb_pos / 2;
      eb_out = mb_sd[d*4 +: 4];
      eb_sel = mb_se[d] ? (3'b001 << d) : 3'b000;
      eb_fs  = mb_init || (mb_pos == 5);
      if (eb_fs) begin
        mb_sd = din_b; mb_se = en_b; mb_init = 1'b0;
      end
      mb_pos = (mb_pos + 1) % 6;
    end
  end

  // Every-cycle comparison against both models, away from the active edge.
  always @(negedge clk) begin
    chk("a_outm", 32'(outm_a), 32'(ea_out));
    chk("a_sel", 32'(selmo_a), 32'(ea_sel));
    chk("a_fs", 32'(fs_a), 32'(ea_fs));
    chk("a_excl", 32'($countones(~selmo_a) <= 1), 32'd1);
    chk("b_outm", 32'(outm_b), 32'(eb_out));
    chk("b_sel", 32'(selmo_b), 32'(eb_sel));
    chk("b_fs", 32'(fs_b), 32'(eb_fs));
    chk("b_excl", 32'($countones(selmo_b) <= 1), 32'd1);
  end

  // Advance to 1 time unit after edge e (counted from reset release).
  task automatic at_edge(input int e);
    for (int k = 0; k < 400; k++) begin
      if (cyc == e) break;
      @(posedge clk);
      #1;
    end
    chk("edge_reached", 32'(cyc), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_a_sel", 32'(selmo_a), 32'hF);
    chk("rst_a_outm", 32'(outm_a), 32'h0);
    chk("rst_b_sel", 32'(selmo_b), 32'h0);
    rst_n = 1'b1;

    at_edge(1);
    chk("l_a_fs1", 32'(fs_a), 32'h1);
    chk("l_a_sel1", 32'(selmo_a), 32'hF);
    chk("l_b_fs1", 32'(fs_b), 32'h1);
    chk("l_b_sel1", 32'(selmo_b), 32'h0);
    at_edge(2);
    chk("l_a_outm2", 32'(outm_a), 32'h1);
    chk("l_a_sel2", 32'(selmo_a), 32'hF);
    chk("l_a_fs2", 32'(fs_a), 32'h0);
    chk("l_b_sel2", 32'(selmo_b), 32'h1);
    chk("l_b_outm2", 32'(outm_b), 32'h1);
    at_edge(3);
    chk("l_a_sel3", 32'(selmo_a), 32'hE);
    chk("l_b_sel3", 32'(selmo_b), 32'h2);
    chk("l_b_outm3", 32'(outm_b), 32'h2);
    at_edge(5);
    chk("l_b_sel5", 32'(selmo_b), 32'h4);
    chk("l_b_outm5", 32'(outm_b), 32'h3);
    at_edge(6);
    chk("l_b_fs6", 32'(fs_b), 32'h1);
    at_edge(7);
    chk("l_b_wrap7", 32'(selmo_b), 32'h1);
    at_edge(11);
    chk("l_a_sel11", 32'(selmo_a), 32'hD);
    chk("l_a_outm11", 32'(outm_a), 32'h2);
    at_edge(19);
    chk("l_a_sel19", 32'(selmo_a), 32'hB);
    chk("l_a_outm19", 32'(outm_a), 32'h3);
    at_edge(27);
    chk("l_a_sel27", 32'(selmo_a), 32'h7);
    chk("l_a_outm27", 32'(outm_a), 32'h4);
    at_edge(32);
    chk("l_a_fs32", 32'(fs_a), 32'h1);

    // New data mid-frame: current frame keeps old digits.
    at_edge(42);
    din_a = 16'h8765;
    at_edge(51);
    chk("l_a_old51", 32'(outm_a), 32'h3);
    at_edge(59);
    chk("l_a_old59", 32'(outm_a), 32'h4);
    at_edge(64);
    chk("l_a_fs64", 32'(fs_a), 32'h1);
    at_edge(67);
    chk("l_a_new67", 32'(outm_a), 32'h5);
    chk("l_a_sel67", 32'(selmo_a), 32'hE);

    // Mask change mid-frame: visible only from the next frame.
    at_edge(70);
    en_a = 4'b0101;
    at_edge(75);
    chk("l_a_sel75", 32'(selmo_a), 32'hD);
    chk("l_a_outm75", 32'(outm_a), 32'h6);
    at_edge(99);
    chk("l_a_sel99", 32'(selmo_a), 32'hE);
    at_edge(107);
    chk("l_a_dis107", 32'(selmo_a), 32'hF);
    at_edge(115);
    chk("l_a_sel115", 32'(selmo_a), 32'hB);
    chk("l_a_outm115", 32'(outm_a), 32'h7);

    // Hold for 10 edges during digit 2's drive window.
    at_edge(148);
    hold_a = 1'b1;
    at_edge(153);
    chk("l_a_hold_sel", 32'(selmo_a), 32'hB);
    chk("l_a_hold_outm", 32'(outm_a), 32'h7);
    chk("l_a_hold_fs", 32'(fs_a), 32'h0);
    at_edge(158);
    hold_a = 1'b0;
    at_edge(162);
    chk("l_a_resume162", 32'(selmo_a), 32'hB);
    at_edge(163);
    chk("l_a_next163", 32'(selmo_a), 32'hF);
    chk("l_a_outm163", 32'(outm_a), 32'h8);

    // Asynchronous reset between edges.
    at_edge(170);
    #3;
    rst_n = 1'b0;
    #1;
    chk("l_arst_sel_a", 32'(selmo_a), 32'hF);
    chk("l_arst_outm_a", 32'(outm_a), 32'h0);
    chk("l_arst_fs_a", 32'(fs_a), 32'h0);
    chk("l_arst_sel_b", 32'(selmo_b), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    at_edge(1);
    chk("l_rs_fs_a", 32'(fs_a), 32'h1);
    at_edge(3);
    chk("l_rs_sel_a", 32'(selmo_a), 32'hE);
    chk("l_rs_outm_a", 32'(outm_a), 32'h5);
    at_edge(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
